// File: rtl/pair_stim_gen_if.sv
// Pair bus from the stimulus generator to the pair checker.
// Handshake: pair_vld is a valid-only strobe with no back-pressure; a, b and
// exp_mismatch are meaningful only in a cycle where pair_vld is high, and the
// consumer must take the pair in that same cycle.
interface pair_stim_gen_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             pair_vld;
  logic             exp_mismatch;

  modport master (output a, output b, output pair_vld, output exp_mismatch);
  modport slave  (input a, input b, input pair_vld, input exp_mismatch);
endinterface

// File: rtl/pair_stim_gen.sv
// Pseudo-random a/b pair generator with optional one-shot mismatch injection.
// One pair per un-stalled RUN cycle; done pulses one cycle after the last pair.
module pair_stim_gen #(
  parameter int          WIDTH = 1,
  parameter int          LEN_W = 8,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             inj_en,
  input  logic [LEN_W-1:0] inj_idx,
  input  logic [WIDTH-1:0] inj_mask,
  input  logic             stall,
  pair_stim_gen_if.master  pair,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] sent_cnt,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  // An all-zero LFSR would lock up, so a zero seed falls back to the default.
  localparam logic [15:0]      SEED_L = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [LEN_W-1:0] ONE    = LEN_W'(1);

  logic [1:0]       state;
  logic [15:0]      lfsr;
  logic [LEN_W-1:0] len_q;
  logic             inj_en_q;
  logic [LEN_W-1:0] inj_idx_q;
  logic [WIDTH-1:0] inj_mask_q;
  logic [LEN_W-1:0] idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             vld_q;
  logic             em_q;
  logic             hit;
  logic             last;
  logic             fb;

  // Injection hit, last-pair detect and LFSR feedback for the current cycle.
  always_comb begin
    hit  = inj_en_q && (idx == inj_idx_q);
    last = (idx == (len_q - ONE));
    fb   = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  end

  // Run control FSM, LFSR and registered pair outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      lfsr       <= SEED_L;
      len_q      <= '0;
      inj_en_q   <= 1'b0;
      inj_idx_q  <= '0;
      inj_mask_q <= '0;
      idx        <= '0;
      sent_cnt   <= '0;
      a_q        <= '0;
      b_q        <= '0;
      vld_q      <= 1'b0;
      em_q       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done  <= 1'b0;
          vld_q <= 1'b0;
          em_q  <= 1'b0;
          if (start) begin
            len_q      <= len;
            inj_en_q   <= inj_en;
            inj_idx_q  <= inj_idx;
            inj_mask_q <= inj_mask;
            idx        <= '0;
            sent_cnt   <= '0;
            state      <= (len != '0) ? RUN : FIN;
          end
        end
        RUN: begin
          if (!stall) begin
            vld_q    <= 1'b1;
            a_q      <= lfsr[WIDTH-1:0];
            b_q      <= lfsr[WIDTH-1:0] ^ (hit ? inj_mask_q : '0);
            em_q     <= hit && (inj_mask_q != '0);
            idx      <= idx + ONE;
            sent_cnt <= sent_cnt + ONE;
            lfsr     <= {fb, lfsr[15:1]};
            if (last) begin
              state <= FIN;
            end
          end else begin
            // a, b, idx and the LFSR hold while stalled.
            vld_q <= 1'b0;
            em_q  <= 1'b0;
          end
        end
        FIN: begin
          vld_q <= 1'b0;
          em_q  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign pair.a            = a_q;
  assign pair.b            = b_q;
  assign pair.pair_vld     = vld_q;
  assign pair.exp_mismatch = em_q;
  assign busy              = (state != IDLE);
  assign state_dbg         = state;

endmodule

// File: tb/tb_pair_stim_gen.sv
// Directed bench for pair_stim_gen at WIDTH=16, so a exposes the full LFSR
// state and the expected values are the hand-stepped LFSR sequence from ACE1.
module tb_pair_stim_gen;

  localparam int W  = 16;
  localparam int LW = 8;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [LW-1:0] len;
  logic          inj_en;
  logic [LW-1:0] inj_idx;
  logic [W-1:0]  inj_mask;
  logic          stall;
  logic          busy;
  logic          done;
  logic [LW-1:0] sent_cnt;
  logic [1:0]    state_dbg;

  int total;
  int bad;

  // Hand-stepped LFSR states: fb = l0^l2^l3^l5, next = {fb, l[15:1]}.
  logic [15:0] seq [0:8];

  pair_stim_gen_if #(.WIDTH(W)) pair ();

  pair_stim_gen #(.WIDTH(W), .LEN_W(LW), .SEED(16'hACE1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .inj_en    (inj_en),
    .inj_idx   (inj_idx),
    .inj_mask  (inj_mask),
    .stall     (stall),
    .pair      (pair),
    .busy      (busy),
    .done      (done),
    .sent_cnt  (sent_cnt),
    .state_dbg (state_dbg)
  );

  // Clock and reset defaults.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Present a start request for one edge (E0), then release it.
  task automatic start_run(input logic [LW-1:0] l, input logic ie,
                           input logic [LW-1:0] ii, input logic [W-1:0] im);
    start    = 1'b1;
    len      = l;
    inj_en   = ie;
    inj_idx  = ii;
    inj_mask = im;
    step();
    start    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    step();
    total++;
    if (pair.a !== 16'h0 || pair.b !== 16'h0 || pair.pair_vld !== 1'b0 ||
        pair.exp_mismatch !== 1'b0 || done !== 1'b0 || sent_cnt !== 8'd0 ||
        busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: a=%h b=%h vld=%b em=%b done=%b cnt=%0d busy=%b, want all 0",
               pair.a, pair.b, pair.pair_vld, pair.exp_mismatch, done, sent_cnt, busy);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    start_run(8'd3, 1'b0, 8'd0, 16'h0);
    total++;
    if (busy !== 1'b1 || pair.pair_vld !== 1'b0) begin
      bad++;
      $display("FAIL basic_e0: busy=%b vld=%b, want busy=1 vld=0", busy, pair.pair_vld);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (pair.pair_vld !== 1'b1 || pair.a !== seq[k] || pair.b !== seq[k] ||
          pair.exp_mismatch !== 1'b0 || sent_cnt !== 8'(k + 1) || done !== 1'b0) begin
        bad++;
        $display("FAIL basic_pair%0d: vld=%b a=%h b=%h em=%b cnt=%0d done=%b, want 1 %h %h 0 %0d 0",
                 k, pair.pair_vld, pair.a, pair.b, pair.exp_mismatch, sent_cnt, done,
                 seq[k], seq[k], k + 1);
      end
    end
    step();
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || pair.pair_vld !== 1'b0 || sent_cnt !== 8'd3 ||
        pair.a !== seq[2]) begin
      bad++;
      $display("FAIL basic_done: done=%b busy=%b vld=%b cnt=%0d a=%h, want 1 0 0 3 %h",
               done, busy, pair.pair_vld, sent_cnt, pair.a, seq[2]);
    end
    step();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL basic_done_pulse: done=%b, want 0", done);
    end
  endtask

  task automatic test_inject();
    logic [15:0] exp_b [0:2];
    logic        exp_e [0:2];
    exp_b[0] = seq[0];
    exp_b[1] = seq[1] ^ 16'h0101;
    exp_b[2] = seq[2];
    exp_e[0] = 1'b0;
    exp_e[1] = 1'b1;
    exp_e[2] = 1'b0;
    do_reset();
    start_run(8'd3, 1'b1, 8'd1, 16'h0101);
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (pair.pair_vld !== 1'b1 || pair.a !== seq[k] || pair.b !== exp_b[k] ||
          pair.exp_mismatch !== exp_e[k]) begin
        bad++;
        $display("FAIL inject_pair%0d: vld=%b a=%h b=%h em=%b, want 1 %h %h %b",
                 k, pair.pair_vld, pair.a, pair.b, pair.exp_mismatch, seq[k], exp_b[k], exp_e[k]);
      end
    end
  endtask

  task automatic test_inj_bounds();
    // inj_idx == len: never reached, so no corruption.
    do_reset();
    start_run(8'd2, 1'b1, 8'd2, 16'hFFFF);
    for (int k = 0; k < 2; k++) begin
      step();
      total++;
      if (pair.pair_vld !== 1'b1 || pair.a !== seq[k] || pair.b !== seq[k] ||
          pair.exp_mismatch !== 1'b0) begin
        bad++;
        $display("FAIL inj_idx_oob_pair%0d: vld=%b a=%h b=%h em=%b, want 1 %h %h 0",
                 k, pair.pair_vld, pair.a, pair.b, pair.exp_mismatch, seq[k], seq[k]);
      end
    end
    step();
    step();
    // Zero mask on a hit index; LFSR carries on from the previous run.
    start_run(8'd1, 1'b1, 8'd0, 16'h0000);
    step();
    total++;
    if (pair.pair_vld !== 1'b1 || pair.a !== seq[2] || pair.b !== seq[2] ||
        pair.exp_mismatch !== 1'b0) begin
      bad++;
      $display("FAIL inj_zero_mask: vld=%b a=%h b=%h em=%b, want 1 %h %h 0",
               pair.pair_vld, pair.a, pair.b, pair.exp_mismatch, seq[2], seq[2]);
    end
  endtask

  task automatic test_stall();
    logic        exp_v [0:5];
    logic [15:0] exp_a [0:5];
    exp_v[0] = 1'b1; exp_a[0] = seq[0];
    exp_v[1] = 1'b1; exp_a[1] = seq[1];
    exp_v[2] = 1'b0; exp_a[2] = seq[1];
    exp_v[3] = 1'b0; exp_a[3] = seq[1];
    exp_v[4] = 1'b1; exp_a[4] = seq[2];
    exp_v[5] = 1'b1; exp_a[5] = seq[3];
    do_reset();
    start_run(8'd4, 1'b0, 8'd0, 16'h0);
    for (int k = 0; k < 6; k++) begin
      stall = (k == 2 || k == 3);
      step();
      total++;
      if (pair.pair_vld !== exp_v[k] || pair.a !== exp_a[k] || pair.b !== exp_a[k] ||
          pair.exp_mismatch !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL stall_cycle%0d: vld=%b a=%h b=%h em=%b done=%b, want %b %h %h 0 0",
                 k, pair.pair_vld, pair.a, pair.b, pair.exp_mismatch, done,
                 exp_v[k], exp_a[k], exp_a[k]);
      end
    end
    stall = 1'b0;
    step();
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || sent_cnt !== 8'd4) begin
      bad++;
      $display("FAIL stall_done: done=%b busy=%b cnt=%0d, want 1 0 4", done, busy, sent_cnt);
    end
  endtask

  task automatic test_len_zero();
    do_reset();
    stall = 1'b1;
    start_run(8'd0, 1'b1, 8'd0, 16'hFFFF);
    total++;
    if (busy !== 1'b1 || state_dbg !== 2'd2 || pair.pair_vld !== 1'b0) begin
      bad++;
      $display("FAIL len0_e0: busy=%b state=%0d vld=%b, want 1 2 0", busy, state_dbg, pair.pair_vld);
    end
    step();
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || pair.pair_vld !== 1'b0 || sent_cnt !== 8'd0) begin
      bad++;
      $display("FAIL len0_done: done=%b busy=%b vld=%b cnt=%0d, want 1 0 0 0",
               done, busy, pair.pair_vld, sent_cnt);
    end
    stall = 1'b0;
    // LFSR must not have advanced with no pairs issued.
    step();
    start_run(8'd1, 1'b0, 8'd0, 16'h0);
    step();
    total++;
    if (pair.pair_vld !== 1'b1 || pair.a !== seq[0]) begin
      bad++;
      $display("FAIL len0_lfsr_hold: vld=%b a=%h, want 1 %h", pair.pair_vld, pair.a, seq[0]);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    start_run(8'd5, 1'b1, 8'd0, 16'h00FF);
    step();
    step();
    rst_n = 1'b0;
    step();
    total++;
    if (pair.a !== 16'h0 || pair.b !== 16'h0 || pair.pair_vld !== 1'b0 ||
        pair.exp_mismatch !== 1'b0 || done !== 1'b0 || sent_cnt !== 8'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset_outputs: a=%h b=%h vld=%b em=%b done=%b cnt=%0d busy=%b, want all 0",
               pair.a, pair.b, pair.pair_vld, pair.exp_mismatch, done, sent_cnt, busy);
    end
    rst_n = 1'b1;
    start_run(8'd3, 1'b0, 8'd0, 16'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (pair.pair_vld !== 1'b1 || pair.a !== seq[k] || pair.b !== seq[k]) begin
        bad++;
        $display("FAIL midreset_restart%0d: vld=%b a=%h b=%h, want 1 %h %h",
                 k, pair.pair_vld, pair.a, pair.b, seq[k], seq[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    start    = 1'b1;
    len      = 8'd3;
    inj_en   = 1'b0;
    inj_idx  = 8'd0;
    inj_mask = 16'h0;
    step();
    // While busy, a changed len on a held start must be ignored.
    len = 8'd2;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (pair.pair_vld !== 1'b1 || pair.a !== seq[k] || sent_cnt !== 8'(k + 1)) begin
        bad++;
        $display("FAIL b2b_run1_pair%0d: vld=%b a=%h cnt=%0d, want 1 %h %0d",
                 k, pair.pair_vld, pair.a, sent_cnt, seq[k], k + 1);
      end
    end
    step();
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || sent_cnt !== 8'd3) begin
      bad++;
      $display("FAIL b2b_done: done=%b busy=%b cnt=%0d, want 1 0 3", done, busy, sent_cnt);
    end
    // Start is still high in the done cycle: second run accepted here.
    step();
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0 || sent_cnt !== 8'd0) begin
      bad++;
      $display("FAIL b2b_accept: busy=%b done=%b cnt=%0d, want 1 0 0", busy, done, sent_cnt);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      total++;
      if (pair.pair_vld !== 1'b1 || pair.a !== seq[3 + k] || sent_cnt !== 8'(k + 1)) begin
        bad++;
        $display("FAIL b2b_run2_pair%0d: vld=%b a=%h cnt=%0d, want 1 %h %0d",
                 k, pair.pair_vld, pair.a, sent_cnt, seq[3 + k], k + 1);
      end
    end
    step();
    total++;
    if (done !== 1'b1 || pair.pair_vld !== 1'b0 || sent_cnt !== 8'd2) begin
      bad++;
      $display("FAIL b2b_done2: done=%b vld=%b cnt=%0d, want 1 0 2", done, pair.pair_vld, sent_cnt);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    len      = '0;
    inj_en   = 1'b0;
    inj_idx  = '0;
    inj_mask = '0;
    stall    = 1'b0;
    seq[0] = 16'hACE1;
    seq[1] = 16'h5670;
    seq[2] = 16'hAB38;
    seq[3] = 16'h559C;
    seq[4] = 16'h2ACE;
    seq[5] = 16'h1567;
    seq[6] = 16'h8AB3;
    seq[7] = 16'h4559;
    seq[8] = 16'h22AC;
    #2;
    test_reset();
    test_basic();
    test_inject();
    test_inj_bounds();
    test_stall();
    test_len_zero();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
